// File: rtl/serial_add_unit.sv
// serial_add_unit: bit-serial add/subtract with valid/ready handshakes.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   operand handshake (a, b, sub); accepted only in IDLE
//   out_valid/out_ready result handshake (sum, c_out, overflow); held in DONE
//   busy                high whenever the block is not IDLE
module serial_add_unit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sh_a, sh_b, sh_s;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             s_bit, co, last;

    // one full-adder cell working on the current LSBs
    assign s_bit = sh_a[0] ^ sh_b[0] ^ carry;
    assign co    = (sh_a[0] & sh_b[0]) | (carry & (sh_a[0] ^ sh_b[0]));
    assign last  = cnt == CW'(WIDTH - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_nxt = RUN;
            end
            RUN:  if (last) state_nxt = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_a     <= '0;
            sh_b     <= '0;
            sh_s     <= '0;
            cnt      <= '0;
            carry    <= 1'b0;
            sum      <= '0;
            c_out    <= 1'b0;
            overflow <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            // subtraction is A + ~B + 1: invert B and seed the carry with sub
            sh_a  <= a;
            sh_b  <= b ^ {WIDTH{sub}};
            carry <= sub;
            cnt   <= '0;
            sh_s  <= '0;
        end else if (state == RUN) begin
            sh_s  <= {s_bit, sh_s[WIDTH-1:1]};
            sh_a  <= sh_a >> 1;
            sh_b  <= sh_b >> 1;
            carry <= co;
            cnt   <= cnt + 1'b1;
            // on the MSB cycle the LSBs of A/B are their original MSBs
            if (last) begin
                sum      <= {s_bit, sh_s[WIDTH-1:1]};
                c_out    <= co;
                overflow <= (sh_a[0] == sh_b[0]) && (s_bit != sh_a[0]);
            end
        end
    end
endmodule

// File: tb/tb_serial_add_unit.sv
// tb_serial_add_unit: directed self-checking bench for serial_add_unit (WIDTH=16).
module tb_serial_add_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] sum;
    logic        c_out;
    logic        overflow;
    logic        busy;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [15:0] a, b;
        logic        s;
        logic [15:0] e;
        logic        c, o;
    } vec_t;

    vec_t vecs[7] = '{
        '{16'h0003, 16'h0005, 1'b0, 16'h0008, 1'b0, 1'b0},
        '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1},
        '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0},
        '{16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0},
        '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1},
        '{16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0},
        '{16'h5555, 16'hAAAA, 1'b0, 16'hFFFF, 1'b0, 1'b0}
    };

    serial_add_unit #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .c_out(c_out), .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        #1;
        total++;
        if ({in_ready, out_valid, busy, sum, c_out, overflow} !== {1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0})
            $display("FAIL reset_async: got rdy=%b ov=%b busy=%b sum=%h c=%b o=%b, want 1 0 0 0000 0 0",
                     in_ready, out_valid, busy, sum, c_out, overflow);
        else passed++;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        total++;
        if ({in_ready, out_valid, busy} !== 3'b100)
            $display("FAIL reset_release: got rdy/ov/busy=%b, want 100", {in_ready, out_valid, busy});
        else passed++;
    endtask

    task automatic test_vectors();
        int n;
        foreach (vecs[i]) begin
            a = vecs[i].a; b = vecs[i].b; sub = vecs[i].s; in_valid = 1'b1;
            @(posedge clk);
            n = 1;
            #1 in_valid = 1'b0;
            a = ~a; b = ~b; sub = ~sub;
            while (!out_valid && n < 40) begin
                @(posedge clk);
                n++;
                #1;
            end
            total++;
            if (n !== 17) $display("FAIL vec%0d_latency: got %0d edges, want 17", i, n);
            else passed++;
            total++;
            if ({sum, c_out, overflow} !== {vecs[i].e, vecs[i].c, vecs[i].o})
                $display("FAIL vec%0d_result: got sum=%h c=%b o=%b, want sum=%h c=%b o=%b",
                         i, sum, c_out, overflow, vecs[i].e, vecs[i].c, vecs[i].o);
            else passed++;
            total++;
            if ({in_ready, busy} !== 2'b01)
                $display("FAIL vec%0d_done_flags: got rdy/busy=%b, want 01", i, {in_ready, busy});
            else passed++;
            out_ready = 1'b1;
            @(posedge clk);
            #1 out_ready = 1'b0;
            total++;
            if ({out_valid, in_ready, busy} !== 3'b010)
                $display("FAIL vec%0d_release: got ov/rdy/busy=%b, want 010", i, {out_valid, in_ready, busy});
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        int n;
        a = 16'h0010; b = 16'h0020; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            n++;
            #1;
        end
        total++;
        if (n !== 17) $display("FAIL hold_latency: got %0d edges, want 17", n);
        else passed++;
        a = 16'hFFFF; b = 16'h0001; sub = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            total++;
            if ({out_valid, in_ready, busy, sum, c_out, overflow} !== {1'b1, 1'b0, 1'b1, 16'h0030, 1'b0, 1'b0})
                $display("FAIL hold_cycle%0d: got ov=%b rdy=%b busy=%b sum=%h c=%b o=%b, want 1 0 1 0030 0 0",
                         k, out_valid, in_ready, busy, sum, c_out, overflow);
            else passed++;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        total++;
        if ({out_valid, in_ready, busy} !== 3'b010)
            $display("FAIL hold_to_idle: got ov/rdy/busy=%b, want 010", {out_valid, in_ready, busy});
        else passed++;
        @(posedge clk);
        #1 in_valid = 1'b0;
        total++;
        if ({in_ready, busy, out_valid, sum} !== {1'b0, 1'b1, 1'b0, 16'h0030})
            $display("FAIL b2b_accept: got rdy=%b busy=%b ov=%b sum=%h, want 0 1 0 0030",
                     in_ready, busy, out_valid, sum);
        else passed++;
        n = 1;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            n++;
            #1;
        end
        total++;
        if ({n[5:0], sum, c_out, overflow} !== {6'd17, 16'h0000, 1'b1, 1'b0})
            $display("FAIL b2b_result: got edges=%0d sum=%h c=%b o=%b, want 17 0000 1 0",
                     n, sum, c_out, overflow);
        else passed++;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset_in_run();
        bit seen = 1'b0;
        a = 16'h0003; b = 16'h0005; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        total++;
        if ({in_ready, busy, out_valid, sum, c_out, overflow} !== {1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0})
            $display("FAIL reset_in_run: got rdy=%b busy=%b ov=%b sum=%h c=%b o=%b, want 1 0 0 0000 0 0",
                     in_ready, busy, out_valid, sum, c_out, overflow);
        else passed++;
        #2 rst_n = 1'b1;
        repeat (30) begin
            @(posedge clk);
            #1 if (out_valid) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL reset_no_result: got seen_out_valid=%b rdy=%b, want 0 1", seen, in_ready);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_back_to_back();
        test_reset_in_run();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
